// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: the bundle of signals around the data-RAM arbiter.
//   m0_* : CPU data-memory port (request fields in, gnt/rvalid/rdata out)
//   m1_* : UART debug loader port (same shape as m0_*)
//   s_*  : single-port RAM side (strobe, write enable, address, data, byte
//          enables out; read data in)
// The 'slave' modport is the arbiter's view: it receives master requests
// and RAM read data, and drives grants, responses and the RAM strobe.
// The 'master' modport is the opposite view, for whatever sits around it.
interface mem_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              m0_req;
    logic              m0_lock;
    logic              m0_we;
    logic [AW-1:0]     m0_addr;
    logic [DW-1:0]     m0_wdata;
    logic [DW/8-1:0]   m0_be;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DW-1:0]     m0_rdata;

    logic              m1_req;
    logic              m1_lock;
    logic              m1_we;
    logic [AW-1:0]     m1_addr;
    logic [DW-1:0]     m1_wdata;
    logic [DW/8-1:0]   m1_be;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DW-1:0]     m1_rdata;

    logic              s_en;
    logic              s_we;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic [DW/8-1:0]   s_be;
    logic [DW-1:0]     s_rdata;

    modport slave (
        input  m0_req, m0_lock, m0_we, m0_addr, m0_wdata, m0_be,
        input  m1_req, m1_lock, m1_we, m1_addr, m1_wdata, m1_be,
        input  s_rdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output s_en, s_we, s_addr, s_wdata, s_be
    );

    modport master (
        output m0_req, m0_lock, m0_we, m0_addr, m0_wdata, m0_be,
        output m1_req, m1_lock, m1_we, m1_addr, m1_wdata, m1_be,
        output s_rdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  s_en, s_we, s_addr, s_wdata, s_be
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master, one-slave arbiter for the single-port data RAM.
// Master 0 is the CPU data port, master 1 the UART debug loader.
// One access is granted per cycle, round-robin with bounded locking; read
// data is steered back to the issuing master through an RD_LAT-deep tag pipe.
// Ports:
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : mem_bus_arbiter_if.slave (both master ports and the RAM port)
module mem_bus_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 8
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_arbiter_if.slave bus
);
    localparam int CW = $clog2(MAX_LOCK + 1);

    logic              last_owner_q, last_owner_d;
    logic [CW-1:0]     lock_cnt_q, lock_cnt_d;
    logic [RD_LAT-1:0] tag_v_q, tag_v_d;
    logic [RD_LAT-1:0] tag_o_q, tag_o_d;
    logic [DW-1:0]     rdata0_q, rdata0_d;
    logic [DW-1:0]     rdata1_q, rdata1_d;

    logic both, last_lock, keep;
    logic gnt0, gnt1, rd_grant;
    logic rv0, rv1;

    // Arbitration. keep is the contested locked re-grant: it can only be
    // true when both request, so it always selects last_owner. Grants are
    // gated by reset so every output is quiet while rst is low.
    always_comb begin
        both      = bus.m0_req & bus.m1_req;
        last_lock = last_owner_q ? bus.m1_lock : bus.m0_lock;
        keep      = both & last_lock & (lock_cnt_q < CW'(MAX_LOCK));
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        if (rst) begin
            if (both) begin
                gnt1 = keep ? last_owner_q : ~last_owner_q;
                gnt0 = ~gnt1;
            end else begin
                gnt0 = bus.m0_req;
                gnt1 = bus.m1_req;
            end
        end
        rd_grant = (gnt0 & ~bus.m0_we) | (gnt1 & ~bus.m1_we);
    end

    // Slave-side mux; fields are zero when nobody is granted.
    always_comb begin
        bus.s_en    = gnt0 | gnt1;
        bus.s_we    = 1'b0;
        bus.s_addr  = '0;
        bus.s_wdata = '0;
        bus.s_be    = '0;
        if (gnt1) begin
            bus.s_we    = bus.m1_we;
            bus.s_addr  = bus.m1_addr;
            bus.s_wdata = bus.m1_wdata;
            bus.s_be    = bus.m1_be;
        end else if (gnt0) begin
            bus.s_we    = bus.m0_we;
            bus.s_addr  = bus.m0_addr;
            bus.s_wdata = bus.m0_wdata;
            bus.s_be    = bus.m0_be;
        end
    end

    // Ownership/lock bookkeeping changes only on a grant. A grant that is not
    // a contested locked re-grant (including the forced hand-over after
    // saturation) clears the counter.
    always_comb begin
        last_owner_d = last_owner_q;
        lock_cnt_d   = lock_cnt_q;
        if (gnt0 | gnt1) begin
            last_owner_d = gnt1;
            lock_cnt_d   = keep ? lock_cnt_q + 1'b1 : '0;
        end
    end

    // Tag pipe shifts every cycle, idle or not; stage RD_LAT-1 lines up with
    // the RAM read data for the grant RD_LAT cycles earlier.
    always_comb begin
        tag_v_d[0] = rd_grant;
        tag_o_d[0] = gnt1;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_v_d[i] = tag_v_q[i-1];
            tag_o_d[i] = tag_o_q[i-1];
        end
    end

    // Read return: owner gets RAM data straight through; the other master's
    // rdata holds its last returned value.
    always_comb begin
        rv0      = tag_v_q[RD_LAT-1] & ~tag_o_q[RD_LAT-1];
        rv1      = tag_v_q[RD_LAT-1] &  tag_o_q[RD_LAT-1];
        rdata0_d = rv0 ? bus.s_rdata : rdata0_q;
        rdata1_d = rv1 ? bus.s_rdata : rdata1_q;
    end

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.m0_rvalid = rv0;
    assign bus.m1_rvalid = rv1;
    assign bus.m0_rdata  = rdata0_d;
    assign bus.m1_rdata  = rdata1_d;

    // Reset sets last_owner to 1 so master 0 wins the first tie, and empties
    // the tag pipe so in-flight reads never return.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner_q <= 1'b1;
            lock_cnt_q   <= '0;
            tag_v_q      <= '0;
            tag_o_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            last_owner_q <= last_owner_d;
            lock_cnt_q   <= lock_cnt_d;
            tag_v_q      <= tag_v_d;
            tag_o_q      <= tag_o_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: three instances (RD_LAT = 1, 2, 3) share one
// stimulus stream; a cycle-level reference model checks every instance at
// each falling edge, and directed sequences pin literal expectations.
module tb_mem_bus_arbiter;
    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int BW       = DW / 8;
    localparam int MAX_LOCK = 8;
    localparam int NI       = 3;

    logic clk;
    logic rst;

    logic          m0_req, m0_lock, m0_we, m1_req, m1_lock, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata, s_rdata;
    logic [BW-1:0] m0_be, m1_be;

    logic          gnt0_a [NI];
    logic          gnt1_a [NI];
    logic          sen_a  [NI];
    logic          swe_a  [NI];
    logic          rv0_a  [NI];
    logic          rv1_a  [NI];
    logic [AW-1:0] saddr_a  [NI];
    logic [DW-1:0] swdata_a [NI];
    logic [BW-1:0] sbe_a    [NI];
    logic [DW-1:0] rd0_a    [NI];
    logic [DW-1:0] rd1_a    [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

        assign bus.m0_req   = m0_req;
        assign bus.m0_lock  = m0_lock;
        assign bus.m0_we    = m0_we;
        assign bus.m0_addr  = m0_addr;
        assign bus.m0_wdata = m0_wdata;
        assign bus.m0_be    = m0_be;
        assign bus.m1_req   = m1_req;
        assign bus.m1_lock  = m1_lock;
        assign bus.m1_we    = m1_we;
        assign bus.m1_addr  = m1_addr;
        assign bus.m1_wdata = m1_wdata;
        assign bus.m1_be    = m1_be;
        assign bus.s_rdata  = s_rdata;

        assign gnt0_a[g]   = bus.m0_gnt;
        assign gnt1_a[g]   = bus.m1_gnt;
        assign sen_a[g]    = bus.s_en;
        assign swe_a[g]    = bus.s_we;
        assign saddr_a[g]  = bus.s_addr;
        assign swdata_a[g] = bus.s_wdata;
        assign sbe_a[g]    = bus.s_be;
        assign rv0_a[g]    = bus.m0_rvalid;
        assign rv1_a[g]    = bus.m1_rvalid;
        assign rd0_a[g]    = bus.m0_rdata;
        assign rd1_a[g]    = bus.m1_rdata;

        mem_bus_arbiter #(
            .AW(AW), .DW(DW), .RD_LAT(g + 1), .MAX_LOCK(MAX_LOCK)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(string name, int inst, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (RD_LAT=%0d) at %0t: got %0h, expected %0h",
                     name, inst + 1, $time, act, exp);
        end
    endfunction

    // Reference model: ownership, lock run length, a log of per-cycle read
    // grants (valid, owner) since reset, and each master's last read data.
    bit            m_last;
    int            m_cnt;
    bit            log_v [$];
    bit            log_o [$];
    logic [DW-1:0] m_rd0 [NI];
    logic [DW-1:0] m_rd1 [NI];

    always @(negedge clk) begin
        bit both, gv, g, lk, wr, ev0, ev1;
        int n;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic [BW-1:0] e_be;
        if (!rst) begin
            for (int i = 0; i < NI; i++) begin
                check("rst_gnt0", i, gnt0_a[i], 0);
                check("rst_gnt1", i, gnt1_a[i], 0);
                check("rst_s_en", i, sen_a[i], 0);
                check("rst_rv0", i, rv0_a[i], 0);
                check("rst_rv1", i, rv1_a[i], 0);
                check("rst_rd0", i, rd0_a[i], 0);
                check("rst_rd1", i, rd1_a[i], 0);
                m_rd0[i] = '0;
                m_rd1[i] = '0;
            end
            m_last = 1'b1;
            m_cnt  = 0;
            log_v.delete();
            log_o.delete();
        end else begin
            both = m0_req && m1_req;
            gv   = m0_req || m1_req;
            lk   = m_last ? m1_lock : m0_lock;
            if (both) g = (lk && m_cnt < MAX_LOCK) ? m_last : !m_last;
            else      g = m1_req;
            wr      = g ? m1_we : m0_we;
            e_addr  = !gv ? '0 : (g ? m1_addr  : m0_addr);
            e_wdata = !gv ? '0 : (g ? m1_wdata : m0_wdata);
            e_be    = !gv ? '0 : (g ? m1_be    : m0_be);
            for (int i = 0; i < NI; i++) begin
                n   = log_v.size();
                ev0 = 1'b0;
                ev1 = 1'b0;
                if (n >= i + 1 && log_v[n-(i+1)]) begin
                    ev0 = !log_o[n-(i+1)];
                    ev1 =  log_o[n-(i+1)];
                end
                if (ev0) m_rd0[i] = s_rdata;
                if (ev1) m_rd1[i] = s_rdata;
                check("gnt0", i, gnt0_a[i], gv && !g);
                check("gnt1", i, gnt1_a[i], gv && g);
                check("s_en", i, sen_a[i], gv);
                check("s_we", i, swe_a[i], gv && wr);
                check("s_addr", i, saddr_a[i], e_addr);
                check("s_wdata", i, swdata_a[i], e_wdata);
                check("s_be", i, sbe_a[i], e_be);
                check("m0_rvalid", i, rv0_a[i], ev0);
                check("m1_rvalid", i, rv1_a[i], ev1);
                check("m0_rdata", i, rd0_a[i], m_rd0[i]);
                check("m1_rdata", i, rd1_a[i], m_rd1[i]);
            end
            if (gv) begin
                if (both && g == m_last && lk && m_cnt < MAX_LOCK) m_cnt++;
                else m_cnt = 0;
                m_last = g;
            end
            log_v.push_back(gv && !wr);
            log_o.push_back(g);
        end
    end

    task automatic clear_inputs();
        m0_req = 0; m0_lock = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_be = '0;
        m1_req = 0; m1_lock = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
    endtask

    // Advance to just after the next rising edge with all masters idle.
    task automatic next();
        @(posedge clk);
        #1;
        clear_inputs();
        s_rdata = $urandom;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        bit e1;
        rst = 1'b0;
        s_rdata = '0;
        clear_inputs();
        do_reset();

        // Lone m0 read at RD_LAT=1.
        next();
        m0_req = 1; m0_addr = 32'h10;
        @(negedge clk);
        check("t1_gnt0", 0, gnt0_a[0], 1);
        check("t1_s_addr", 0, saddr_a[0], 32'h10);
        check("t1_s_we", 0, swe_a[0], 0);
        next();
        s_rdata = 32'hA5A50001;
        @(negedge clk);
        check("t1_rv0", 0, rv0_a[0], 1);
        check("t1_rd0", 0, rd0_a[0], 32'hA5A50001);
        check("t1_rv1", 0, rv1_a[0], 0);

        // Contested unlocked reads alternate starting with m0.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            next();
            m0_req = 1; m0_addr = 32'h100 + k;
            m1_req = 1; m1_addr = 32'h200 + k;
            @(negedge clk);
            check("t2_gnt0", 0, gnt0_a[0], (k % 2) == 0);
            check("t2_gnt1", 0, gnt1_a[0], (k % 2) == 1);
            if (k > 0) check("t2_rv0", 0, rv0_a[0], (k % 2) == 1);
        end

        // m1 locked: 9 grants, one hand-over to m0, then m1 again.
        do_reset();
        next();
        m1_req = 1; m1_lock = 1;
        @(negedge clk);
        check("t3_first_gnt1", 0, gnt1_a[0], 1);
        for (int k = 1; k < 12; k++) begin
            next();
            m0_req = 1; m1_req = 1; m1_lock = 1;
            e1 = (k <= 8) || (k >= 10);
            @(negedge clk);
            check("t3_gnt1", 0, gnt1_a[0], e1);
            check("t3_gnt0", 0, gnt0_a[0], !e1);
        end

        // m1 write with partial byte enables.
        do_reset();
        next();
        m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'hDEADBEEF; m1_be = 4'b0011;
        @(negedge clk);
        check("t4_gnt1", 0, gnt1_a[0], 1);
        check("t4_s_en", 0, sen_a[0], 1);
        check("t4_s_we", 0, swe_a[0], 1);
        check("t4_s_wdata", 0, swdata_a[0], 32'hDEADBEEF);
        check("t4_s_be", 0, sbe_a[0], 4'b0011);
        for (int k = 0; k < 3; k++) begin
            next();
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                check("t4_rv0", i, rv0_a[i], 0);
                check("t4_rv1", i, rv1_a[i], 0);
            end
        end

        // RD_LAT=3 back-to-back reads m0, m1, m0.
        do_reset();
        next(); m0_req = 1; m0_addr = 32'h1;
        next(); m1_req = 1; m1_addr = 32'h2;
        next(); m0_req = 1; m0_addr = 32'h3;
        next(); s_rdata = 32'h11110000;
        @(negedge clk);
        check("t5_c3_rv0", 2, rv0_a[2], 1);
        check("t5_c3_rd0", 2, rd0_a[2], 32'h11110000);
        check("t5_c3_rv1", 2, rv1_a[2], 0);
        next(); s_rdata = 32'h22220000;
        @(negedge clk);
        check("t5_c4_rv1", 2, rv1_a[2], 1);
        check("t5_c4_rd1", 2, rd1_a[2], 32'h22220000);
        check("t5_c4_rv0", 2, rv0_a[2], 0);
        check("t5_c4_rd0_hold", 2, rd0_a[2], 32'h11110000);
        next(); s_rdata = 32'h33330000;
        @(negedge clk);
        check("t5_c5_rv0", 2, rv0_a[2], 1);
        check("t5_c5_rd0", 2, rd0_a[2], 32'h33330000);

        // Reset one cycle after an m0 read grant at RD_LAT=2.
        do_reset();
        next(); m0_req = 1; m0_addr = 32'h44;
        @(negedge clk);
        check("t6_gnt0", 1, gnt0_a[1], 1);
        next(); m0_req = 1; m0_addr = 32'h48;
        rst = 1'b0;
        #1;
        check("t6_rst_gnt0", 1, gnt0_a[1], 0);
        check("t6_rst_s_en", 1, sen_a[1], 0);
        check("t6_rst_s_addr", 1, saddr_a[1], 0);
        check("t6_rst_rv0", 1, rv0_a[1], 0);
        check("t6_rst_rd0", 1, rd0_a[1], 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m0_req = 0;
        for (int k = 0; k < 3; k++) begin
            next();
            @(negedge clk);
            check("t6_no_rv0", 1, rv0_a[1], 0);
        end
        next(); m0_req = 1; m1_req = 1;
        @(negedge clk);
        check("t6_first_tie_gnt0", 1, gnt0_a[1], 1);

        // Randomized traffic with occasional asynchronous resets.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            next();
            rst      = ($urandom_range(0, 99) != 0);
            m0_req   = ($urandom_range(0, 3) != 0);
            m1_req   = ($urandom_range(0, 3) != 0);
            m0_lock  = ($urandom_range(0, 3) != 0);
            m1_lock  = ($urandom_range(0, 3) != 0);
            m0_we    = ($urandom_range(0, 2) == 0);
            m1_we    = ($urandom_range(0, 2) == 0);
            m0_addr  = $urandom;
            m1_addr  = $urandom;
            m0_wdata = $urandom;
            m1_wdata = $urandom;
            m0_be    = BW'($urandom);
            m1_be    = BW'($urandom);
        end
        next();
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the SoC's single-port data RAM.
- Master 0 is the CPU data-memory port; master 1 is the UART debug loader, which writes program and data images over UART.
- Grants one access per cycle using round-robin with optional bounded locking.
- Tracks outstanding reads so read data returns to the master that issued them.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits; byte enables are DW/8 bits.
- RD_LAT, 1, fixed slave read latency in cycles; legal range 1..4.
- MAX_LOCK, 8, maximum consecutive locked grants to one master while the other is requesting.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- m0_req  in  1  master 0 access request
- m0_lock  in  1  master 0 asks to keep ownership next cycle
- m0_we  in  1  master 0 write enable (1=write, 0=read)
- m0_addr  in  AW  master 0 address
- m0_wdata  in  DW  master 0 write data
- m0_be  in  DW/8  master 0 byte enables
- m0_gnt  out  1  master 0 access accepted this cycle
- m0_rvalid  out  1  master 0 read data valid
- m0_rdata  out  DW  master 0 read data
- m1_req, m1_lock, m1_we, m1_addr, m1_wdata, m1_be  in  as master 0  master 1 request fields
- m1_gnt, m1_rvalid, m1_rdata  out  as master 0  master 1 responses
- s_en  out  1  slave access strobe
- s_we  out  1  slave write enable
- s_addr  out  AW  slave address
- s_wdata  out  DW  slave write data
- s_be  out  DW/8  slave byte enables
- s_rdata  in  DW  slave read data, valid RD_LAT cycles after s_en with s_we=0

Behaviour:
- Reset (rst=0, asynchronous):
  - last_owner=1, so master 0 wins the first tie.
  - lock_cnt=0 and the tag pipeline is cleared.
  - All rvalid and gnt outputs are 0; s_en=0; rdata outputs are 0.
- Arbitration is combinational within the cycle:
  - m*_gnt, s_en and the s_* fields depend on the current requests and registered state.
  - A request is accepted in any cycle where gnt=1.
  - The master holds its request fields until gnt; holding is a master obligation, not checked here.
- Selection order:
  - (a) If exactly one master requests, grant it.
  - (b) If both request and last_owner has lock=1 and lock_cnt<MAX_LOCK, grant last_owner.
  - (c) Otherwise, if both request, grant the master that is not last_owner.
- s_en = m0_gnt | m1_gnt.
- s_we, s_addr, s_wdata and s_be are muxed from the granted master. When idle they are driven to 0.
- Registered updates on each grant:
  - last_owner <= granted index.
  - lock_cnt increments when the grant is a contested locked re-grant; otherwise it clears.
  - Saturation forces case (c) for one arbitration; lock_cnt then clears.
  - An uncontested master may hold the bus indefinitely.
- Read return:
  - Each read grant pushes {valid=1, owner} into an RD_LAT-deep shift register; writes and idle cycles push valid=0.
  - At the output stage, m<owner>_rvalid=1 and m<owner>_rdata=s_rdata.
  - The non-owner sees rvalid=0 and its rdata holds its last value.
  - Read latency is exactly RD_LAT cycles from the grant cycle. The return path is fully pipelined, so one read can be accepted per cycle with no stalls.
- Writes complete in the grant cycle and produce no response.
- Simultaneous read return and new grant are independent; both occur in the same cycle.
- Reset mid-operation discards in-flight reads: no rvalid is ever produced for them.
- The tag pipeline is updated every cycle, so read returns continue even while neither master requests.

Test Plan:
- Reset, then m0 reads addr 0x10 alone with RD_LAT=1 -> m0_gnt=1 in cycle 0; s_addr=0x10, s_we=0; m0_rvalid=1 in cycle 1 with m0_rdata=s_rdata; m1_rvalid stays 0.
- Both masters hold requests, lock=0, for 6 cycles starting after reset -> grants alternate m0,m1,m0,m1,m0,m1; read returns route to the matching master in order.
- Both request, m1 holds lock=1, MAX_LOCK=8, m1 granted first -> m1 granted 9 consecutive cycles (first grant plus 8 locked re-grants), then m0 is granted once, then m1 resumes.
- m1 writes 0xDEADBEEF with be=4'b0011 to 0x20 while m0 is idle -> s_en=1, s_we=1, s_wdata=0xDEADBEEF, s_be=4'b0011; no rvalid on either master.
- RD_LAT=3, back-to-back reads m0,m1,m0 in cycles 0-2 -> rvalid on m0 in cycle 3, m1 in cycle 4, m0 in cycle 5, each with the correct s_rdata.
- rst asserted 1 cycle after an m0 read grant (RD_LAT=2) -> all outputs 0 immediately; no m0_rvalid after rst is released; the first contested grant after reset goes to m0.
